elc_scan_ctrl: RTL and testbench

- Parametrised next-generation elevator controller for N_FLOORS floors, one-hot floor encoding.
- Latches multiple outstanding floor requests into a pending mask and serves them in SCAN order: continue in the current direction while requests remain ahead, then reverse.
- Adds timed floor-to-floor travel, timed door dwell, and door/weight alerts that hold the car.
- Sits between the floor-button/cabin-sensor logic and the motor/door drivers.

---
 rtl/elc_pkg.sv | 27 ++
 rtl/elc_tick_counter.sv | 31 +++
 rtl/elc_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_elc_scan_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elc_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// Floor vectors are handled at a fixed maximum width inside the helpers.
package elc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } elc_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int ELC_MAX_FLOORS = 32;
    typedef logic [ELC_MAX_FLOORS-1:0] elc_vec_t;

    // All floors strictly above the one-hot floor.
    function automatic elc_vec_t elc_above_mask(input elc_vec_t onehot);
        return ~((onehot << 1) - elc_vec_t'(1));
    endfunction

    // All floors strictly below the one-hot floor.
    function automatic elc_vec_t elc_below_mask(input elc_vec_t onehot);
        return onehot - elc_vec_t'(1);
    endfunction

endpackage

// File: rtl/elc_tick_counter.sv
// Wrapping 0..MAX-1 tick counter; done flags the last tick of a period.
// clear restarts from 0, hold freezes the count.
module elc_tick_counter #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic hold_i,
    output logic done_o
);

    localparam int CW = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] count_q;

    assign done_o = !clear_i && !hold_i && (count_q == LAST);

    // Tick count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= CW'(0);
        end else if (clear_i || done_o) begin
            count_q <= CW'(0);
        end else if (!hold_i) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/elc_scan_ctrl.sv
// SCAN-order elevator controller: latches requests into a pending mask,
// travels floor by floor with timed moves and a timed, holdable door dwell.
import elc_pkg::*;

module elc_scan_ctrl #(
    parameter int N_FLOORS    = 8,
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 6,
    parameter int RESET_FLOOR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [N_FLOORS-1:0] req_floor,
    input  logic                over_time,
    input  logic                over_weight,
    output logic [N_FLOORS-1:0] out_current_floor,
    output logic                direction,
    output logic                moving,
    output logic                door_open,
    output logic                complete,
    output logic                door_alert,
    output logic                weight_alert,
    output logic [N_FLOORS-1:0] pending
);

    localparam logic [N_FLOORS-1:0] ZERO_VEC     = {N_FLOORS{1'b0}};
    localparam logic [N_FLOORS-1:0] RESET_ONEHOT = {{(N_FLOORS-1){1'b0}}, 1'b1} << RESET_FLOOR;

    elc_state_e          state_q;
    logic [N_FLOORS-1:0] cur_q;
    logic [N_FLOORS-1:0] pending_q;
    logic [N_FLOORS-1:0] pending_d;
    logic                dir_q;
    logic                moving_q;
    logic                door_open_q;
    logic                complete_q;
    logic                door_alert_q;
    logic                weight_alert_q;

    logic [N_FLOORS-1:0] serve_s;
    logic [N_FLOORS-1:0] next_floor_s;
    logic                ahead_up_s;
    logic                ahead_dn_s;
    logic                fwd_s;
    logic                back_s;
    logic                here_s;
    logic                arrive_s;
    logic                absorb_s;
    logic                travel_done_s;
    logic                dwell_done_s;

    assign ahead_up_s   = |(elc_vec_t'(pending_q) & elc_above_mask(elc_vec_t'(cur_q)));
    assign ahead_dn_s   = |(elc_vec_t'(pending_q) & elc_below_mask(elc_vec_t'(cur_q)));
    assign fwd_s        = dir_q ? ahead_up_s : ahead_dn_s;
    assign back_s       = dir_q ? ahead_dn_s : ahead_up_s;
    assign here_s       = |(cur_q & pending_q);
    assign next_floor_s = dir_q ? (cur_q << 1) : (cur_q >> 1);
    assign arrive_s     = (state_q == MOVE) && travel_done_s && |(next_floor_s & pending_q);
    assign absorb_s     = (state_q == DOOR) && req_valid && |(req_floor & cur_q);

    elc_tick_counter #(.MAX(FLOOR_TICKS)) u_travel (
        .clk_i   (clk),
        .rst_n_i (reset),
        .clear_i (state_q != MOVE),
        .hold_i  (1'b0),
        .done_o  (travel_done_s)
    );

    // Alerts and same-floor requests pin the dwell at its first tick.
    elc_tick_counter #(.MAX(DOOR_TICKS)) u_dwell (
        .clk_i   (clk),
        .rst_n_i (reset),
        .clear_i ((state_q != DOOR) || over_time || over_weight || absorb_s),
        .hold_i  (1'b0),
        .done_o  (dwell_done_s)
    );

    // Floor being served this cycle and next pending mask
    always_comb begin
        serve_s = ZERO_VEC;
        if (state_q == DOOR) begin
            serve_s = cur_q;
        end else if ((state_q == IDLE) && here_s) begin
            serve_s = cur_q;
        end else if (arrive_s) begin
            serve_s = next_floor_s;
        end else begin
            serve_s = ZERO_VEC;
        end
        pending_d = (pending_q & ~serve_s) | (req_valid ? (req_floor & ~serve_s) : ZERO_VEC);
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cur_q          <= RESET_ONEHOT;
            dir_q          <= DIR_UP;
            pending_q      <= ZERO_VEC;
            moving_q       <= 1'b0;
            door_open_q    <= 1'b0;
            complete_q     <= 1'b0;
            door_alert_q   <= 1'b0;
            weight_alert_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            complete_q     <= 1'b0;
            door_alert_q   <= over_time && (state_q == DOOR);
            weight_alert_q <= over_weight && (state_q != MOVE);
            case (state_q)
                IDLE: begin
                    if (here_s) begin
                        state_q     <= DOOR;
                        door_open_q <= 1'b1;
                        complete_q  <= 1'b1;
                    end else if (over_weight) begin
                        state_q <= IDLE;
                    end else if (ahead_up_s && (dir_q || !ahead_dn_s)) begin
                        dir_q    <= DIR_UP;
                        state_q  <= MOVE;
                        moving_q <= 1'b1;
                    end else if (ahead_dn_s) begin
                        dir_q    <= DIR_DN;
                        state_q  <= MOVE;
                        moving_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MOVE: begin
                    if (travel_done_s) begin
                        cur_q <= next_floor_s;
                        if (arrive_s) begin
                            state_q     <= DOOR;
                            moving_q    <= 1'b0;
                            door_open_q <= 1'b1;
                            complete_q  <= 1'b1;
                        end
                    end
                end
                DOOR: begin
                    if (dwell_done_s) begin
                        door_open_q <= 1'b0;
                        if (fwd_s) begin
                            state_q  <= MOVE;
                            moving_q <= 1'b1;
                        end else if (back_s) begin
                            dir_q    <= ~dir_q;
                            state_q  <= MOVE;
                            moving_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    moving_q    <= 1'b0;
                    door_open_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_current_floor = cur_q;
    assign direction         = dir_q;
    assign moving            = moving_q;
    assign door_open         = door_open_q;
    assign complete          = complete_q;
    assign door_alert        = door_alert_q;
    assign weight_alert      = weight_alert_q;
    assign pending           = pending_q;

endmodule

// File: tb/tb_elc_scan_ctrl.sv
// Bench for elc_scan_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a floor-index/timer reference model.
module tb_elc_scan_ctrl;

    localparam int N  = 8;
    localparam int FT = 4;
    localparam int DT = 6;
    localparam int RF = 0;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic [N-1:0] req_floor = '0;
    logic         over_time = 1'b0;
    logic         over_weight = 1'b0;
    logic [N-1:0] out_current_floor;
    logic         direction;
    logic         moving;
    logic         door_open;
    logic         complete;
    logic         door_alert;
    logic         weight_alert;
    logic [N-1:0] pending;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int           m_floor;
    int           m_mode;
    int           m_tr;
    int           m_dw;
    bit           m_dir;
    bit           m_cmp;
    bit           m_da;
    bit           m_wa;
    logic [N-1:0] m_pend;

    elc_scan_ctrl #(
        .N_FLOORS(N), .FLOOR_TICKS(FT), .DOOR_TICKS(DT), .RESET_FLOOR(RF)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .over_time(over_time), .over_weight(over_weight),
        .out_current_floor(out_current_floor), .direction(direction),
        .moving(moving), .door_open(door_open), .complete(complete),
        .door_alert(door_alert), .weight_alert(weight_alert), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_floor = RF; m_mode = M_IDLE; m_tr = 0; m_dw = 0;
        m_dir = 1'b1; m_cmp = 1'b0; m_da = 1'b0; m_wa = 1'b0; m_pend = '0;
    endtask

    task automatic model_step(input bit rv, input logic [N-1:0] rf, input bit ot, input bit ow);
        logic [N-1:0] serve;
        bit up, dn, ncmp;
        int nf;
        serve = '0; up = 1'b0; dn = 1'b0; ncmp = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && i > m_floor) up = 1'b1;
            if (m_pend[i] && i < m_floor) dn = 1'b1;
        end
        m_da = ot && (m_mode == M_DOOR);
        m_wa = ow && (m_mode != M_MOVE);
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    serve[m_floor] = 1'b1; m_mode = M_DOOR; m_dw = 0; ncmp = 1'b1;
                end else if (!ow) begin
                    if (up && (m_dir || !dn)) begin
                        m_dir = 1'b1; m_mode = M_MOVE; m_tr = 0;
                    end else if (dn) begin
                        m_dir = 1'b0; m_mode = M_MOVE; m_tr = 0;
                    end
                end
            end
            M_MOVE: begin
                if (m_tr == FT - 1) begin
                    m_tr = 0;
                    nf = m_dir ? m_floor + 1 : m_floor - 1;
                    if (nf >= 0 && nf < N) m_floor = nf;
                    if (m_pend[m_floor]) begin
                        serve[m_floor] = 1'b1; m_mode = M_DOOR; m_dw = 0; ncmp = 1'b1;
                    end
                end else begin
                    m_tr++;
                end
            end
            default: begin
                serve[m_floor] = 1'b1;
                if (ot || ow || (rv && rf[m_floor])) begin
                    m_dw = 0;
                end else if (m_dw == DT - 1) begin
                    m_dw = 0;
                    if (m_dir ? up : dn) begin
                        m_mode = M_MOVE; m_tr = 0;
                    end else if (m_dir ? dn : up) begin
                        m_dir = !m_dir; m_mode = M_MOVE; m_tr = 0;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end else begin
                    m_dw++;
                end
            end
        endcase
        m_pend = (m_pend & ~serve) | (rv ? (rf & ~serve) : '0);
        m_cmp  = ncmp;
    endtask

    task automatic compare_all();
        check_eq("floor",        32'(out_current_floor), 32'(1) << m_floor);
        check_eq("floor_onehot", 32'($onehot(out_current_floor)), 32'd1);
        check_eq("direction",    32'(direction),    32'(m_dir));
        check_eq("moving",       32'(moving),       32'(m_mode == M_MOVE));
        check_eq("door_open",    32'(door_open),    32'(m_mode == M_DOOR));
        check_eq("complete",     32'(complete),     32'(m_cmp));
        check_eq("door_alert",   32'(door_alert),   32'(m_da));
        check_eq("weight_alert", 32'(weight_alert), 32'(m_wa));
        check_eq("pending",      32'(pending),      32'(m_pend));
    endtask

    task automatic step(input bit rv, input logic [N-1:0] rf, input bit ot, input bit ow);
        req_valid = rv; req_floor = rf; over_time = ot; over_weight = ow;
        @(posedge clk);
        model_step(rv, rf, ot, ow);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_door(input string tag);
        int i;
        i = 0;
        while (!door_open && i < 200) begin
            idle();
            i++;
        end
        check_eq(tag, 32'(door_open), 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        int i;
        i = 0;
        while ((door_open || moving || pending != '0) && i < 300) begin
            idle();
            i++;
        end
        check_eq(tag, 32'(door_open || moving), 32'd0);
    endtask

    initial begin
        int dc, wa, mv, cp;
        logic [N-1:0] served[$];
        bit dir_at_last;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare_all();

        // request floor 2 from floor 0
        step(1'b1, 8'b0000_0100, 1'b0, 1'b0);
        check_eq("s1_pending", 32'(pending), 32'h04);
        idle();
        check_eq("s1_moving", 32'(moving), 32'd1);
        repeat (4) idle();
        check_eq("s1_floor1", 32'(out_current_floor), 32'h02);
        repeat (4) idle();
        check_eq("s1_floor2", 32'(out_current_floor), 32'h04);
        check_eq("s1_complete", 32'(complete), 32'd1);
        dc = 1; cp = 1;
        repeat (11) begin
            idle();
            dc += int'(door_open);
            cp += int'(complete);
        end
        check_eq("s1_door_cycles", 32'(dc), 32'(DT));
        check_eq("s1_complete_count", 32'(cp), 32'd1);
        check_eq("s1_idle", 32'(moving || door_open), 32'd0);

        // floor 5 requested, floor 1 added while passing floor 3 going up
        step(1'b1, 8'b0010_0000, 1'b0, 1'b0);
        for (int i = 0; i < 50 && out_current_floor != 8'h08; i++) idle();
        check_eq("s2_at3", 32'(out_current_floor), 32'h08);
        step(1'b1, 8'b0000_0010, 1'b0, 1'b0);
        dir_at_last = 1'b1;
        for (int i = 0; i < 200 && (pending != '0 || moving || door_open); i++) begin
            idle();
            if (complete) begin
                served.push_back(out_current_floor);
                dir_at_last = direction;
            end
        end
        check_eq("s2_served_count", 32'(served.size()), 32'd2);
        if (served.size() == 2) begin
            check_eq("s2_first", 32'(served[0]), 32'h20);
            check_eq("s2_second", 32'(served[1]), 32'h02);
        end
        check_eq("s2_dir_down", 32'(dir_at_last), 32'd0);
        check_eq("s2_pending_empty", 32'(pending), 32'd0);

        // door at floor 2 held by over_weight for 10 cycles
        step(1'b1, 8'b0000_0100, 1'b0, 1'b0);
        wait_door("s3_door");
        check_eq("s3_floor", 32'(out_current_floor), 32'h04);
        dc = 1; wa = 0; mv = 0;
        repeat (10) begin
            step(1'b0, '0, 1'b0, 1'b1);
            wa += int'(weight_alert); dc += int'(door_open); mv += int'(moving);
        end
        repeat (12) begin
            idle();
            wa += int'(weight_alert); dc += int'(door_open); mv += int'(moving);
        end
        check_eq("s3_weight_alert_cycles", 32'(wa), 32'd10);
        check_eq("s3_door_cycles", 32'(dc), 32'(10 + DT));
        check_eq("s3_no_move", 32'(mv), 32'd0);

        // both alerts together mid-dwell at floor 4
        step(1'b1, 8'b0001_0000, 1'b0, 1'b0);
        wait_door("s4_door");
        idle();
        idle();
        repeat (3) begin
            step(1'b0, '0, 1'b1, 1'b1);
            check_eq("s4_door_alert", 32'(door_alert), 32'd1);
            check_eq("s4_weight_alert", 32'(weight_alert), 32'd1);
        end
        idle();
        check_eq("s4_door_alert_drop", 32'(door_alert), 32'd0);
        check_eq("s4_weight_alert_drop", 32'(weight_alert), 32'd0);
        // the last held cycle was dwell tick 0, so DT-1 ticks remain from here
        dc = int'(door_open);
        repeat (8) begin
            idle();
            dc += int'(door_open);
        end
        check_eq("s4_dwell_restart", 32'(dc), 32'(DT - 1));

        // request for the current floor while the door is open at floor 6
        step(1'b1, 8'b0100_0000, 1'b0, 1'b0);
        wait_door("s5_door");
        idle();
        idle();
        step(1'b1, 8'b0100_0000, 1'b0, 1'b0);
        check_eq("s5_not_latched", 32'(pending), 32'd0);
        dc = int'(door_open); cp = int'(complete);
        repeat (8) begin
            idle();
            dc += int'(door_open);
            cp += int'(complete);
        end
        check_eq("s5_dwell_restart", 32'(dc), 32'(DT));
        check_eq("s5_no_second_complete", 32'(cp), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 5) == 0, N'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
        end
        wait_quiet("rand_settle");

        // async reset in the middle of a move between floors 4 and 5
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'b1000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 100 && out_current_floor != 8'h10; i++) idle();
        check_eq("s7_at4", 32'(out_current_floor), 32'h10);
        idle();
        check_eq("s7_moving", 32'(moving), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("s7_rst_floor", 32'(out_current_floor), 32'(1) << RF);
        check_eq("s7_rst_pending", 32'(pending), 32'd0);
        check_eq("s7_rst_moving", 32'(moving), 32'd0);
        check_eq("s7_rst_direction", 32'(direction), 32'd1);
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        repeat (5) idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
